// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b computed LSB first as a + ~b + 1
// through one full-adder cell with a registered carry. start/busy/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_sh_q;
  logic [WIDTH-1:0]  b_sh_q;
  logic [WIDTH-1:0]  res_sh_q;
  logic [CntW-1:0]   cnt_q;
  logic              carry_q;
  // Carry into the MSB, kept for the signed-overflow check.
  logic              msb_cin_q;
  // Set once every bit is processed; the following cycle publishes the result.
  logic              last_q;

  logic              nb_bit;
  logic              sum_bit;
  logic              carry_nxt;

  // Single full-adder cell on the current LSBs, subtrahend inverted.
  always_comb begin
    nb_bit    = ~b_sh_q[0];
    sum_bit   = a_sh_q[0] ^ nb_bit ^ carry_q;
    carry_nxt = (a_sh_q[0] & nb_bit) | (carry_q & (a_sh_q[0] ^ nb_bit));
  end

  // Control FSM, serial datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_sh_q   <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      msb_cin_q  <= 1'b0;
      last_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      difference <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= 1'b1;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          if (!last_q) begin
            res_sh_q <= {sum_bit, res_sh_q[WIDTH-1:1]};
            a_sh_q   <= a_sh_q >> 1;
            b_sh_q   <= b_sh_q >> 1;
            carry_q  <= carry_nxt;
            // Counter saturates at WIDTH-1 rather than wrapping.
            if (cnt_q == CntW'(WIDTH - 1)) begin
              last_q    <= 1'b1;
              msb_cin_q <= carry_q;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end else begin
            difference <= res_sh_q;
            borrow_out <= ~carry_q;
            overflow   <= msb_cin_q ^ carry_q;
            busy       <= 1'b0;
            done       <= 1'b1;
            state_q    <= StDone;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a 32-bit and an 8-bit instance share
// clock, reset, start and operand low bits; results compared to an arithmetic model.
module tb_serial_subtractor;

  localparam int W      = 32;
  localparam int W8     = 8;
  localparam int Budget = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done, borrow_out, overflow;
  logic [31:0] difference;
  logic        busy8, done8, borrow8, overflow8;
  logic [7:0]  difference8;

  int checks = 0;
  int errors = 0;
  bit overlap = 1'b0;

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  serial_subtractor #(.WIDTH(W8)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a[7:0]),
    .b          (b[7:0]),
    .busy       (busy8),
    .done       (done8),
    .difference (difference8),
    .borrow_out (borrow8),
    .overflow   (overflow8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on a w-bit word.
  function automatic void ref_sub(input logic [31:0] x, input logic [31:0] y, input int w,
                                  output logic [31:0] d, output logic bo, output logic ov);
    longint mask, half, ux, uy, sx, sy, sd;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ux   = longint'(x) & mask;
    uy   = longint'(y) & mask;
    sx   = (ux >= half) ? ux - 2 * half : ux;
    sy   = (uy >= half) ? uy - 2 * half : uy;
    sd   = sx - sy;
    d    = 32'((ux - uy) & mask);
    bo   = (ux < uy);
    ov   = (sd < -half) || (sd >= half);
  endfunction

  task automatic do_start(input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for the 32-bit done, capturing the 8-bit done on the way; optional start poke.
  task automatic wait_done(input int poke, input logic [31:0] pa, input logic [31:0] pb,
                           output int lat, output int lat8,
                           output logic [31:0] d, output logic bo, output logic ov,
                           output logic [7:0] d8, output logic bo8, output logic ov8);
    lat = 0; lat8 = 0; d = '0; bo = 1'b0; ov = 1'b0; d8 = '0; bo8 = 1'b0; ov8 = 1'b0;
    for (int n = 1; n <= Budget; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (poke != 0 && n == poke + 1) start = 1'b0;
      if ((busy && done) || (busy8 && done8)) overlap = 1'b1;
      if (done8 && lat8 == 0) begin
        lat8 = n; d8 = difference8; bo8 = borrow8; ov8 = overflow8;
      end
      if (done) begin
        lat = n; d = difference; bo = borrow_out; ov = overflow;
        break;
      end
      if (poke != 0 && n == poke) begin
        chk("busy_mid_run", 32'(busy), 32'd1);
        start = 1'b1; a = pa; b = pb;
      end
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] ed,
                        input logic ebo, input logic eov);
    int lat, lat8;
    logic [31:0] d, m8;
    logic bo, ov, bo8, ov8, mbo, mov;
    logic [7:0] d8;
    do_start(x, y);
    wait_done(0, '0, '0, lat, lat8, d, bo, ov, d8, bo8, ov8);
    chk("latency32", 32'(lat), 32'(W + 1));
    chk("difference32", d, ed);
    chk("borrow32", 32'(bo), 32'(ebo));
    chk("overflow32", 32'(ov), 32'(eov));
    ref_sub(x, y, W8, m8, mbo, mov);
    chk("latency8", 32'(lat8), 32'(W8 + 1));
    chk("difference8", {24'b0, d8}, m8);
    chk("borrow8", 32'(bo8), 32'(mbo));
    chk("overflow8", 32'(ov8), 32'(mov));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return {24'h0, 8'h80};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, lat8, cnt;
    logic [31:0] d, rx, ry, rd;
    logic bo, ov, bo8, ov8, rbo, rov;
    logic [7:0] d8;

    tbl[0] = '{32'd5,         32'd3,         32'd2,         1'b0, 1'b0};
    tbl[1] = '{32'd3,         32'd5,         32'hFFFF_FFFE, 1'b1, 1'b0};
    tbl[2] = '{32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 1'b1};
    tbl[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
    tbl[4] = '{32'd0,         32'd0,         32'd0,         1'b0, 1'b0};
    tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0};
    tbl[6] = '{32'd0,         32'd1,         32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1};
    tbl[8] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_difference", difference, 32'd0);
    chk("reset_borrow", 32'(borrow_out), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table; consecutive entries start in the previous DONE cycle.
    for (int i = 0; i < 9; i++) run_op(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo, tbl[i].ov);

    for (int i = 0; i < 1000; i++) begin
      rx = pick();
      ry = pick();
      ref_sub(rx, ry, W, rd, rbo, rov);
      run_op(rx, ry, rd, rbo, rov);
    end

    // Start while busy is ignored: one done, original operands.
    repeat (3) @(negedge clk);
    do_start(32'd10, 32'd4);
    wait_done(5, 32'd100, 32'd1, lat, lat8, d, bo, ov, d8, bo8, ov8);
    chk("ignore_latency", 32'(lat), 32'(W + 1));
    chk("ignore_difference", d, 32'd6);
    chk("ignore_difference8", {24'b0, d8}, 32'd6);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || done8) cnt++;
    end
    chk("ignore_extra_done", 32'(cnt), 32'd0);

    // Back-to-back: start held in the DONE cycle.
    run_op(32'd20, 32'd7, 32'd13, 1'b0, 1'b0);
    run_op(32'd7, 32'd20, 32'hFFFF_FFF3, 1'b1, 1'b0);

    // Reset mid-operation.
    @(negedge clk);
    do_start(32'd9, 32'd2);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_difference", difference, 32'd0);
    chk("midrst_borrow", 32'(borrow_out), 32'd0);
    chk("midrst_busy8", 32'(busy8), 32'd0);
    chk("midrst_difference8", {24'b0, difference8}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || done8) cnt++;
    end
    chk("midrst_no_done", 32'(cnt), 32'd0);
    run_op(32'd9, 32'd2, 32'd7, 1'b0, 1'b0);

    chk("busy_done_overlap", 32'(overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
